// File: rtl/abacus_event_counter.sv
// abacus_event_counter: twelve core trace event counters with a start/stop/clear
// command FSM and a one-cycle-latency read port.
// Build macro ABACUS_COUNTER_SATURATE_EN: when defined, a counter holds at all-ones
// instead of wrapping to zero. Overflow flags behave the same in both builds.
//
// state     | meaning
// IDLE      | after reset; events are not counted
// COUNTING  | captured events increment their counters
// FROZEN    | stopped; counters hold until restarted or cleared
module abacus_event_counter #(
    parameter int COUNTER_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          abacus_instruction,
    input  logic                 abacus_instruction_issued,
    input  logic                 abacus_icache_request,
    input  logic                 abacus_icache_miss,
    input  logic                 abacus_icache_line_fill_in_progress,
    input  logic                 abacus_dcache_request,
    input  logic                 abacus_dcache_hit,
    input  logic                 abacus_dcache_line_fill_in_progress,
    input  logic                 ctrl_start,
    input  logic                 ctrl_stop,
    input  logic                 ctrl_clear,
    input  logic                 rd_en,
    input  logic [3:0]           rd_addr,
    output logic                 rd_valid,
    output logic [COUNTER_W-1:0] rd_data,
    output logic                 counting
);

    localparam int NUM_CNT = 12;
    localparam logic [COUNTER_W-1:0] CNT_ONE = {{(COUNTER_W-1){1'b0}}, 1'b1};

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_FROZEN   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CNT-1:0]   evt_raw;
    logic [NUM_CNT-1:0]   evt_q, evt_d;
    logic [COUNTER_W-1:0] cnt_q [NUM_CNT];
    logic [COUNTER_W-1:0] cnt_d [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf_q, ovf_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [COUNTER_W-1:0] rd_data_q, rd_data_d;
    logic [63:0]          rd_ext;
    logic [6:0]           opcode;
    logic                 unused_instr_bits;

    // Only the opcode field matters for classification.
    assign opcode            = abacus_instruction[6:0];
    assign unused_instr_bits = ^abacus_instruction[31:7];

    assign counting = (state_q == ST_COUNTING);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    // Command decode; stop takes priority over a simultaneous start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_start && !ctrl_stop) state_d = ST_COUNTING;
            end
            ST_COUNTING: begin
                if (ctrl_stop) state_d = ST_FROZEN;
            end
            ST_FROZEN: begin
                if (ctrl_start && !ctrl_stop) state_d = ST_COUNTING;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Raw event vector in counter order; the capture stage keeps only events seen while counting.
    always_comb begin
        evt_raw     = '0;
        evt_raw[0]  = 1'b1;
        evt_raw[1]  = abacus_instruction_issued;
        evt_raw[2]  = abacus_instruction_issued && (opcode == OP_LOAD);
        evt_raw[3]  = abacus_instruction_issued && (opcode == OP_STORE);
        evt_raw[4]  = abacus_instruction_issued && (opcode == OP_BRANCH);
        evt_raw[5]  = abacus_instruction_issued && ((opcode == OP_JAL) || (opcode == OP_JALR));
        evt_raw[6]  = abacus_icache_request;
        evt_raw[7]  = abacus_icache_miss;
        evt_raw[8]  = abacus_icache_line_fill_in_progress;
        evt_raw[9]  = abacus_dcache_request;
        evt_raw[10] = abacus_dcache_hit;
        evt_raw[11] = abacus_dcache_line_fill_in_progress;
        if (ctrl_clear) begin
            evt_d = '0;
        end else begin
            evt_d = evt_raw & {NUM_CNT{state_q == ST_COUNTING}};
        end
    end

    // Counter and sticky-overflow update from the capture stage; clear beats increment.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (ctrl_clear) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (evt_q[i]) begin
                if (cnt_q[i] == {COUNTER_W{1'b1}}) begin
                    ovf_d[i] = 1'b1;
`ifdef ABACUS_COUNTER_SATURATE_EN
                    cnt_d[i] = cnt_q[i];
`else
                    cnt_d[i] = '0;
`endif
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Read mux; rd_data only reloads when a read is requested so it holds between responses.
    always_comb begin
        rd_ext = '0;
        if (rd_addr < 4'd12) begin
            rd_ext[COUNTER_W-1:0] = cnt_q[rd_addr];
        end else if (rd_addr == 4'd12) begin
            rd_ext[NUM_CNT-1:0] = ovf_q;
        end else if (rd_addr == 4'd13) begin
            rd_ext[1:0] = state_q;
        end
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? rd_ext[COUNTER_W-1:0] : rd_data_q;
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture stage, counters and overflow flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q <= '0;
            ovf_q <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            evt_q <= evt_d;
            ovf_q <= ovf_d;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Read response registers; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_abacus_event_counter.sv
// Directed bench for abacus_event_counter. A 32-bit instance and an 8-bit
// instance share every input; the 8-bit one exercises counter overflow.
// Honours ABACUS_COUNTER_SATURATE_EN for the expected overflow value.
module tb_abacus_event_counter;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        issued;
    logic        ic_req, ic_miss, ic_fill;
    logic        dc_req, dc_hit, dc_fill;
    logic        ctrl_start, ctrl_stop, ctrl_clear;
    logic        rd_en;
    logic [3:0]  rd_addr;

    logic        rd_valid, rd_valid8;
    logic [31:0] rd_data;
    logic [7:0]  rd_data8;
    logic        counting, counting8;

    int errors;
    int checks;

    localparam logic [31:0] I_LW   = 32'h00412083;
    localparam logic [31:0] I_SW   = 32'h00112223;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JAL  = 32'h0080006F;
    localparam logic [31:0] I_ADD  = 32'h002081B3;

`ifdef ABACUS_COUNTER_SATURATE_EN
    localparam logic [63:0] EXP_MISS8 = 64'd255;
`else
    localparam logic [63:0] EXP_MISS8 = 64'd44;
`endif

    abacus_event_counter dut (
        .clk                                 (clk),
        .rst_n                               (rst_n),
        .abacus_instruction                  (instr),
        .abacus_instruction_issued           (issued),
        .abacus_icache_request               (ic_req),
        .abacus_icache_miss                  (ic_miss),
        .abacus_icache_line_fill_in_progress (ic_fill),
        .abacus_dcache_request               (dc_req),
        .abacus_dcache_hit                   (dc_hit),
        .abacus_dcache_line_fill_in_progress (dc_fill),
        .ctrl_start                          (ctrl_start),
        .ctrl_stop                           (ctrl_stop),
        .ctrl_clear                          (ctrl_clear),
        .rd_en                               (rd_en),
        .rd_addr                             (rd_addr),
        .rd_valid                            (rd_valid),
        .rd_data                             (rd_data),
        .counting                            (counting)
    );

    abacus_event_counter #(.COUNTER_W(8)) dut8 (
        .clk                                 (clk),
        .rst_n                               (rst_n),
        .abacus_instruction                  (instr),
        .abacus_instruction_issued           (issued),
        .abacus_icache_request               (ic_req),
        .abacus_icache_miss                  (ic_miss),
        .abacus_icache_line_fill_in_progress (ic_fill),
        .abacus_dcache_request               (dc_req),
        .abacus_dcache_hit                   (dc_hit),
        .abacus_dcache_line_fill_in_progress (dc_fill),
        .ctrl_start                          (ctrl_start),
        .ctrl_stop                           (ctrl_stop),
        .ctrl_clear                          (ctrl_clear),
        .rd_en                               (rd_en),
        .rd_addr                             (rd_addr),
        .rd_valid                            (rd_valid8),
        .rd_data                             (rd_data8),
        .counting                            (counting8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle read: after the returning tick the response is on the outputs.
    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [63:0] exp);
        rd_addr = a;
        rd_en   = 1'b1;
        tick();
        rd_en   = 1'b0;
        chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
        chk(tag, 64'(rd_data), exp);
    endtask

    int          exp_b [12];
    logic [31:0] b_instr [11];
    logic        b_iss [11];

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        instr      = '0;
        issued     = 1'b0;
        ic_req     = 1'b0;
        ic_miss    = 1'b0;
        ic_fill    = 1'b0;
        dc_req     = 1'b0;
        dc_hit     = 1'b0;
        dc_fill    = 1'b0;
        ctrl_start = 1'b0;
        ctrl_stop  = 1'b0;
        ctrl_clear = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;

        // Reset state.
        tick();
        tick();
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_counting", 64'(counting), 64'd0);
        rst_n = 1'b1;
        tick();
        rd_chk("rst_cnt0", 4'd0, 64'd0);

        // Events in IDLE are not counted.
        issued = 1'b1; instr = I_LW; ic_miss = 1'b1; dc_hit = 1'b1; ic_req = 1'b1;
        tick(); tick(); tick();
        issued = 1'b0; instr = '0; ic_miss = 1'b0; dc_hit = 1'b0; ic_req = 1'b0;
        tick(); tick();
        rd_chk("idle_cnt0", 4'd0, 64'd0);
        rd_chk("idle_cnt1", 4'd1, 64'd0);
        rd_chk("idle_cnt7", 4'd7, 64'd0);
        rd_chk("idle_cnt10", 4'd10, 64'd0);
        rd_chk("idle_state", 4'd13, 64'd0);

        // Instruction mix: 4 loads, 3 stores, 2 branches, 1 jal, plus one unissued load.
        b_instr = '{I_LW, I_SW, I_LW, I_BEQ, I_SW, I_LW, I_JAL, I_BEQ, I_SW, I_LW, I_LW};
        b_iss   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        chk("b_counting", 64'(counting), 64'd1);
        chk("b_counting8", 64'(counting8), 64'd1);
        for (int k = 0; k < 11; k++) begin
            instr  = b_instr[k];
            issued = b_iss[k];
            ic_req = 1'b1;
            dc_req = (k < 5);
            tick();
        end
        instr = '0; issued = 1'b0; ic_req = 1'b0; dc_req = 1'b0;
        ctrl_stop = 1'b1;
        tick();
        ctrl_stop = 1'b0;
        chk("b_frozen_counting", 64'(counting), 64'd0);
        tick(); tick();
        // Counting lasted 12 cycles (loop of 11 plus the stop cycle).
        exp_b = '{12, 10, 4, 3, 2, 1, 11, 0, 0, 5, 0, 0};
        for (int i = 0; i < 12; i++) begin
            rd_chk($sformatf("b_cnt%0d", i), 4'(i), 64'(exp_b[i]));
        end
        rd_chk("b_state", 4'd13, 64'd2);
        rd_chk("b_ovf", 4'd12, 64'd0);

        // Back-to-back reads, then rd_data holds while rd_valid is low.
        rd_addr = 4'd1; rd_en = 1'b1;
        tick();
        chk("btb0_valid", 64'(rd_valid), 64'd1);
        chk("btb0_data", 64'(rd_data), 64'd10);
        rd_addr = 4'd2;
        tick();
        rd_en = 1'b0;
        chk("btb1_valid", 64'(rd_valid), 64'd1);
        chk("btb1_data", 64'(rd_data), 64'd4);
        tick();
        chk("hold_valid", 64'(rd_valid), 64'd0);
        chk("hold_data", 64'(rd_data), 64'd4);
        rd_chk("addr14", 4'd14, 64'd0);
        rd_chk("addr15", 4'd15, 64'd0);

        // Events and a stop while FROZEN change nothing.
        issued = 1'b1; instr = I_LW; ic_miss = 1'b1; dc_hit = 1'b1; ctrl_stop = 1'b1;
        tick();
        ctrl_stop = 1'b0;
        tick(); tick();
        issued = 1'b0; instr = '0; ic_miss = 1'b0; dc_hit = 1'b0;
        tick(); tick();
        rd_chk("frz_cnt0", 4'd0, 64'd12);
        rd_chk("frz_cnt1", 4'd1, 64'd10);
        rd_chk("frz_cnt7", 4'd7, 64'd0);
        rd_chk("frz_cnt10", 4'd10, 64'd0);
        rd_chk("frz_state", 4'd13, 64'd2);

        // Clear coincident with a dcache hit while COUNTING.
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        chk("d_counting", 64'(counting), 64'd1);
        dc_hit = 1'b1;
        tick();
        ctrl_clear = 1'b1;
        tick();
        ctrl_clear = 1'b0; dc_hit = 1'b0;
        tick(); tick();
        rd_chk("d_cnt10", 4'd10, 64'd0);
        rd_chk("d_cnt1", 4'd1, 64'd0);
        rd_chk("d_state", 4'd13, 64'd1);
        chk("d_counting_after", 64'(counting), 64'd1);
        dc_hit = 1'b1;
        tick();
        dc_hit = 1'b0;
        tick(); tick();
        rd_chk("d_cnt10_next", 4'd10, 64'd1);

        // 300 icache misses: 32-bit counts them all, 8-bit overflows.
        for (int k = 0; k < 300; k++) begin
            ic_miss = 1'b1;
            ic_req  = (k < 4);
            ic_fill = (k < 7);
            dc_fill = (k < 9);
            tick();
        end
        ic_miss = 1'b0; ic_req = 1'b0; ic_fill = 1'b0; dc_fill = 1'b0;
        tick(); tick();
        rd_chk("e_cnt7", 4'd7, 64'd300);
        chk("e_cnt7_w8", 64'(rd_data8), EXP_MISS8);
        rd_chk("e_cnt6", 4'd6, 64'd4);
        rd_chk("e_cnt8", 4'd8, 64'd7);
        rd_chk("e_cnt11", 4'd11, 64'd9);
        rd_chk("e_ovf", 4'd12, 64'd0);
        chk("e_ovf_w8_bit7", 64'(rd_data8[7]), 64'd1);
        chk("e_ovf_w8_valid", 64'(rd_valid8), 64'd1);

        // Start and stop together from COUNTING: stop wins.
        ctrl_start = 1'b1; ctrl_stop = 1'b1;
        tick();
        ctrl_start = 1'b0; ctrl_stop = 1'b0;
        chk("f_counting", 64'(counting), 64'd0);
        rd_chk("f_state", 4'd13, 64'd2);

        // Reset mid-read with a capture in flight.
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        ic_miss = 1'b1; rd_addr = 4'd7; rd_en = 1'b1;
        tick();
        chk("g_pre_valid", 64'(rd_valid), 64'd1);
        chk("g_pre_data", 64'(rd_data), 64'd300);
        #2;
        rst_n = 1'b0;
        #1;
        chk("g_rst_valid", 64'(rd_valid), 64'd0);
        chk("g_rst_data", 64'(rd_data), 64'd0);
        chk("g_rst_counting", 64'(counting), 64'd0);
        chk("g_rst_valid8", 64'(rd_valid8), 64'd0);
        ic_miss = 1'b0; rd_en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("g_post_valid", 64'(rd_valid), 64'd0);
        for (int a = 0; a < 16; a++) begin
            rd_chk($sformatf("g_addr%0d", a), 4'(a), 64'd0);
        end

        // Start and stop together from IDLE: stays IDLE; then a plain start.
        ctrl_start = 1'b1; ctrl_stop = 1'b1;
        tick();
        ctrl_start = 1'b0; ctrl_stop = 1'b0;
        chk("h_counting", 64'(counting), 64'd0);
        rd_chk("h_state", 4'd13, 64'd0);
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        chk("h_counting_start", 64'(counting), 64'd1);
        rd_chk("h_state_start", 4'd13, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/abacus_event_counter.md
ABACUS_EVENT_COUNTER -- requirements
Module: abacus_event_counter

Interface
REQ-001 SHALL have parameter COUNTER_W, default 32: width of each event counter; legal range 8..64.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have inputs abacus_instruction (32), abacus_instruction_issued (1), abacus_icache_request, abacus_icache_miss, abacus_icache_line_fill_in_progress, abacus_dcache_request, abacus_dcache_hit, abacus_dcache_line_fill_in_progress (1 each): core trace events.
REQ-005 SHALL have inputs ctrl_start, ctrl_stop, ctrl_clear (1 each): single-cycle command pulses.
REQ-006 SHALL have inputs rd_en (1) and rd_addr (4): counter read request.
REQ-007 SHALL have outputs rd_valid (1) and rd_data (COUNTER_W): read response.
REQ-008 SHALL have output counting (1): high while in state COUNTING.

Function
REQ-009 SHALL register all event inputs in one capture stage; a counter increments on the edge after capture, i.e. an event at cycle N is visible in a counter at cycle N+2.
REQ-010 SHALL implement states IDLE, COUNTING, FROZEN; IDLE->COUNTING on ctrl_start; COUNTING->FROZEN on ctrl_stop; FROZEN->COUNTING on ctrl_start; ctrl_start in COUNTING and ctrl_stop in IDLE/FROZEN are ignored.
REQ-011 SHALL, when ctrl_start and ctrl_stop are high together, apply ctrl_stop only.
REQ-012 SHALL increment counters only for captured events whose capture cycle had state COUNTING.
REQ-013 SHALL map counters: 0 cycles in COUNTING, 1 issued instructions, 2 loads (opcode 0000011), 3 stores (0100011), 4 branches (1100011), 5 jumps (1101111 or 1100111), 6 icache requests, 7 icache misses, 8 icache fill cycles, 9 dcache requests, 10 dcache hits, 11 dcache fill cycles.
REQ-014 SHALL classify counters 2-5 from abacus_instruction[6:0] only when abacus_instruction_issued is high.
REQ-015 SHALL keep one sticky overflow flag per counter 0-11, set when an increment is applied at all-ones; cleared only by ctrl_clear or reset.
REQ-016 SHALL, on ctrl_clear, zero all counters, overflow flags and the capture stage on the next edge without changing state; clear wins over any same-cycle increment.
REQ-017 SHALL return, one cycle after rd_en, rd_valid=1 and rd_data = counter value at the rd_en edge; addr 12 = overflow flags zero-extended; addr 13 = state code (IDLE 0, COUNTING 1, FROZEN 2) zero-extended; addr 14-15 = 0.
REQ-018 SHALL hold rd_data stable while rd_valid is low; back-to-back reads give one response per cycle.
REQ-019 SHALL drive counting combinationally from the state register.

Reset
REQ-020 SHALL on rst_n low asynchronously set state IDLE and zero all counters, flags, capture stage, rd_valid, rd_data.
REQ-021 SHALL discard any in-flight read or capture when reset asserts mid-operation; first valid response is for an rd_en sampled after reset release.

Configuration
REQ-022 SHALL, with macro ABACUS_COUNTER_SATURATE_EN defined, hold a counter at all-ones on further increments.
REQ-023 SHALL, without ABACUS_COUNTER_SATURATE_EN, wrap a counter from all-ones to zero; overflow flags behave identically in both builds.

Verification
REQ-024 SHALL cover: start, 10 issued instrs (4 loads, 3 stores, 2 branches, 1 jal), stop -> counters 1..5 = 10,4,3,2,1; counter 0 = cycles between start and stop.
REQ-025 SHALL cover: events while IDLE and FROZEN -> all counters unchanged; addr 13 reads 0 then 2.
REQ-026 SHALL cover: COUNTER_W=8, 300 icache misses -> counter 7 = 255 (saturate build) or 44 (wrap build); addr 12 bit 7 = 1.
REQ-027 SHALL cover: ctrl_clear coincident with dcache hit while COUNTING -> counter 10 = 0, state still COUNTING, next hit yields 1.
REQ-028 SHALL cover: ctrl_start+ctrl_stop same cycle from COUNTING -> FROZEN; reset asserted mid-read -> rd_valid 0, all reads 0 after release.
